frame_swap_ctrl: RTL and testbench
==================================

// Module: frame_swap_ctrl
// PURPOSE
//  Responder side of the render/display frame handshake. Accepts frame_clear and frame_render_done from the render sequencer.
//  Sweeps clear values into the back buffer, arbitrates the buffer write port between the clear sweep and the render pipeline,
//  and flips the active render target on the next display frame start, then pulses frame_swapped. Single clk domain.
// PARAMETERS
//  DISPLAY_WIDTH   320   pixels per line
//  DISPLAY_HEIGHT  240   lines per frame
//  ADDRWIDTH       $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)   pixel address width
//  FB_DATA_WIDTH   4     colour-index width
//  DB_DATA_WIDTH   12    depth width
//  FB_CLEAR_VALUE  0     colour written by clear sweep
//  DB_CLEAR_VALUE  '1    depth written by clear sweep (far plane)
// PORTS
//  clk                     in   1    system clock (clk_100m)
//  rst                     in   1    asynchronous, active-high reset
//  frame_clear             in   1    request clear of current render target (level or pulse; sampled in READY)
//  frame_render_done       in   1    render finished; swap at next i_frame_start
//  i_frame_start           in   1    1-cycle display frame-start pulse, already synchronised to clk
//  new_frame_render_ready  out  1    high = render target cleared/idle, writes accepted
//  frame_swapped           out  1    1-cycle pulse when target flips
//  o_render_target         out  1    buffer index rendered into; display scans the other
//  o_write_dropped         out  1    sticky: a pipeline write was discarded
//  i_pixel_write_addr      in   ADDRWIDTH      pipeline write address
//  i_pixel_write_valid     in   1              pipeline write strobe
//  i_fb_data               in   FB_DATA_WIDTH  pipeline colour
//  i_db_data               in   DB_DATA_WIDTH  pipeline depth
//  o_buf_write_en          out  1              buffer write strobe
//  o_buf_write_addr        out  ADDRWIDTH      buffer write address
//  o_buf_write_sel         out  1              buffer written (= o_render_target)
//  o_fb_data / o_db_data   out  FB_/DB_DATA_WIDTH   write data
// BEHAVIOUR
//  Reset (async): state READY; new_frame_render_ready=1; frame_swapped=0; o_render_target=0; o_write_dropped=0;
//   o_buf_write_en=0; addr/data outputs=0; clear counter=0. Reset mid-sweep aborts it; no partial state survives.
//  FSM READY -> CLEARING on frame_clear; new_frame_render_ready low from next cycle; o_write_dropped cleared.
//   READY -> WAIT_SWAP on frame_render_done (frame_clear has priority if both are high).
//   CLEARING -> READY after the write to addr W*H-1; new_frame_render_ready high the following cycle.
//   WAIT_SWAP -> READY on i_frame_start: o_render_target toggles, frame_swapped=1 for exactly that one registered cycle.
//  Clear sweep: one write per cycle, addr 0..W*H-1 ascending.
//   o_buf_write_en=1, data=FB_/DB_CLEAR_VALUE. Exactly W*H cycles; first write in the first CLEARING cycle.
//  Pipeline writes: in READY, registered pass-through (1-cycle latency) to o_buf_*.
//   Dropped, with o_write_dropped set, when: in CLEARING or WAIT_SWAP, or addr >= W*H.
//  Ignored events: frame_clear in CLEARING/WAIT_SWAP; frame_render_done outside READY; i_frame_start outside WAIT_SWAP.
//  i_frame_start in the same cycle as frame_render_done (READY): no swap; wait for the next i_frame_start.
//  Counter width ADDRWIDTH; terminal compare against W*H-1 (no wrap-around reliance).
//  All outputs registered; no combinational path from any input to any output.
// STRUCTURE
//  frame_ctrl_pkg: state_t enum {READY, CLEARING, WAIT_SWAP}; localparam PIXEL_COUNT = W*H.
//  Sub-module fb_clear_sweeper: start, busy, last, addr counter. Top holds FSM, write mux, target flop.
// TESTING (bench with W=4, H=2 plus one default-size run)
//  1 Reset release -> ready=1, target=0, write_en=0; rst asserted mid-cycle forces these asynchronously.
//  2 frame_clear 1 cycle -> ready=0 next cycle; 8 writes addr 0..7, fb=0, db=12'hFFF; ready=1 after addr 7.
//  3 In READY: write addr 5, fb=3, db=12'h123 -> next cycle write_en=1, addr 5, sel=target, data unchanged.
//  4 Write during CLEARING and write to addr 8 -> neither reaches o_buf_*; o_write_dropped=1 until next frame_clear.
//  5 render_done, then i_frame_start 10 cycles later -> frame_swapped 1-cycle pulse, target 0->1; repeat -> 1->0.
//  6 frame_clear+render_done same cycle -> clear runs, no swap.
//    render_done+i_frame_start same cycle -> swap only on next i_frame_start.

Source files
------------

// File: rtl/frame_ctrl_pkg.sv
// Shared types and default geometry for the render/display frame swap logic.
// Contents: state_t FSM encoding, default display size and pixel count.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        CLEARING  = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 320;
    localparam int DEF_HEIGHT  = 240;
    localparam int PIXEL_COUNT = DEF_WIDTH * DEF_HEIGHT;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address generator for the back-buffer clear sweep (0..NUM_PIXELS-1, one per cycle).
// Ports: clk, rst (async high), start, busy, last (current write is final), addr (next write address).
module fb_clear_sweeper
    import frame_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS = PIXEL_COUNT,
    parameter int ADDRWIDTH  = $clog2(NUM_PIXELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 last,
    output logic [ADDRWIDTH-1:0] addr
);

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUM_PIXELS - 1);

    // cnt_q mirrors the address currently presented on the registered write port
    logic                 busy_q, busy_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (cnt_q == LAST_ADDR) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + ADDRWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign last = busy_q && (cnt_q == LAST_ADDR);
    // Address to load into the output register at the coming edge
    assign addr = (start && !busy_q) ? '0 : cnt_q + ADDRWIDTH'(1);

endmodule

// File: rtl/frame_swap_ctrl.sv
// Responder side of the render/display frame handshake: clear sweep, write-port arbitration, target flip.
// Ports: frame_clear/frame_render_done/i_frame_start in; ready, frame_swapped, target, write_dropped out;
// pipeline write in (addr/valid/fb/db); registered buffer write port out (en/addr/sel/fb/db).
module frame_swap_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_HEIGHT,
    parameter int ADDRWIDTH      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    parameter int FB_DATA_WIDTH  = 4,
    parameter int DB_DATA_WIDTH  = 12,
    parameter logic [FB_DATA_WIDTH-1:0] FB_CLEAR_VALUE = '0,
    parameter logic [DB_DATA_WIDTH-1:0] DB_CLEAR_VALUE = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_clear,
    input  logic                     frame_render_done,
    input  logic                     i_frame_start,
    output logic                     new_frame_render_ready,
    output logic                     frame_swapped,
    output logic                     o_render_target,
    output logic                     o_write_dropped,
    input  logic [ADDRWIDTH-1:0]     i_pixel_write_addr,
    input  logic                     i_pixel_write_valid,
    input  logic [FB_DATA_WIDTH-1:0] i_fb_data,
    input  logic [DB_DATA_WIDTH-1:0] i_db_data,
    output logic                     o_buf_write_en,
    output logic [ADDRWIDTH-1:0]     o_buf_write_addr,
    output logic                     o_buf_write_sel,
    output logic [FB_DATA_WIDTH-1:0] o_fb_data,
    output logic [DB_DATA_WIDTH-1:0] o_db_data
);

    localparam int NUM_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUM_PIXELS - 1);

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     swapped_q, swapped_d;
    logic                     target_q, target_d;
    logic                     dropped_q, dropped_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDRWIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [FB_DATA_WIDTH-1:0] fb_q, fb_d;
    logic [DB_DATA_WIDTH-1:0] db_q, db_d;

    logic                 sweep_start;
    logic                 sweep_busy;
    logic                 sweep_last;
    logic [ADDRWIDTH-1:0] sweep_addr;
    logic                 pix_in_range;

    fb_clear_sweeper #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDRWIDTH  (ADDRWIDTH)
    ) u_sweeper (
        .clk   (clk),
        .rst   (rst),
        .start (sweep_start),
        .busy  (sweep_busy),
        .last  (sweep_last),
        .addr  (sweep_addr)
    );

    assign pix_in_range = (i_pixel_write_addr <= LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        swapped_d   = 1'b0;
        target_d    = target_q;
        dropped_d   = dropped_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        fb_d        = fb_q;
        db_d        = db_q;
        sweep_start = 1'b0;

        unique case (state_q)
            READY: begin
                if (frame_clear) begin
                    // Clear owns the write port from this edge; a
                    // coincident pipeline write is discarded.
                    state_d     = CLEARING;
                    ready_d     = 1'b0;
                    dropped_d   = i_pixel_write_valid;
                    sweep_start = 1'b1;
                    wr_en_d     = 1'b1;
                    wr_addr_d   = sweep_addr;
                    fb_d        = FB_CLEAR_VALUE;
                    db_d        = DB_CLEAR_VALUE;
                end else begin
                    if (frame_render_done) begin
                        state_d = WAIT_SWAP;
                        ready_d = 1'b0;
                    end
                    if (i_pixel_write_valid) begin
                        if (pix_in_range) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = i_pixel_write_addr;
                            fb_d      = i_fb_data;
                            db_d      = i_db_data;
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end
                end
            end
            CLEARING: begin
                if (i_pixel_write_valid) begin
                    dropped_d = 1'b1;
                end
                if (sweep_last || !sweep_busy) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = sweep_addr;
                    fb_d      = FB_CLEAR_VALUE;
                    db_d      = DB_CLEAR_VALUE;
                end
            end
            WAIT_SWAP: begin
                if (i_pixel_write_valid) begin
                    dropped_d = 1'b1;
                end
                if (i_frame_start) begin
                    state_d   = READY;
                    ready_d   = 1'b1;
                    target_d  = ~target_q;
                    swapped_d = 1'b1;
                end
            end
            default: begin
                state_d = READY;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= READY;
            ready_q   <= 1'b1;
            swapped_q <= 1'b0;
            target_q  <= 1'b0;
            dropped_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            fb_q      <= '0;
            db_q      <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            swapped_q <= swapped_d;
            target_q  <= target_d;
            dropped_q <= dropped_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            fb_q      <= fb_d;
            db_q      <= db_d;
        end
    end

    assign new_frame_render_ready = ready_q;
    assign frame_swapped          = swapped_q;
    assign o_render_target        = target_q;
    assign o_write_dropped        = dropped_q;
    assign o_buf_write_en         = wr_en_q;
    assign o_buf_write_addr       = wr_addr_q;
    // Writes only happen while the target is stable, so sel is the target flop
    assign o_buf_write_sel        = target_q;
    assign o_fb_data              = fb_q;
    assign o_db_data              = db_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed self-checking bench for frame_swap_ctrl: a 4x2 instance plus a default 320x240 instance.
// Ports: none (top-level bench).
module tb_frame_swap_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Small 4x2 instance; address widened so addr 8 is expressible
    logic        a_clear, a_done, a_fs, a_valid;
    logic [3:0]  a_addr, a_fb_in;
    logic [11:0] a_db_in;
    logic        a_ready, a_swapped, a_target, a_dropped;
    logic        a_en, a_sel;
    logic [3:0]  a_waddr, a_fb;
    logic [11:0] a_db;

    frame_swap_ctrl #(
        .DISPLAY_WIDTH  (4),
        .DISPLAY_HEIGHT (2),
        .ADDRWIDTH      (4)
    ) dut_a (
        .clk                    (clk),
        .rst                    (rst),
        .frame_clear            (a_clear),
        .frame_render_done      (a_done),
        .i_frame_start          (a_fs),
        .new_frame_render_ready (a_ready),
        .frame_swapped          (a_swapped),
        .o_render_target        (a_target),
        .o_write_dropped        (a_dropped),
        .i_pixel_write_addr     (a_addr),
        .i_pixel_write_valid    (a_valid),
        .i_fb_data              (a_fb_in),
        .i_db_data              (a_db_in),
        .o_buf_write_en         (a_en),
        .o_buf_write_addr       (a_waddr),
        .o_buf_write_sel        (a_sel),
        .o_fb_data              (a_fb),
        .o_db_data              (a_db)
    );

    // Default-size instance
    logic        b_clear, b_done, b_fs, b_valid;
    logic [16:0] b_addr;
    logic [3:0]  b_fb_in;
    logic [11:0] b_db_in;
    logic        b_ready, b_swapped, b_target, b_dropped;
    logic        b_en, b_sel;
    logic [16:0] b_waddr;
    logic [3:0]  b_fb;
    logic [11:0] b_db;

    frame_swap_ctrl dut_b (
        .clk                    (clk),
        .rst                    (rst),
        .frame_clear            (b_clear),
        .frame_render_done      (b_done),
        .i_frame_start          (b_fs),
        .new_frame_render_ready (b_ready),
        .frame_swapped          (b_swapped),
        .o_render_target        (b_target),
        .o_write_dropped        (b_dropped),
        .i_pixel_write_addr     (b_addr),
        .i_pixel_write_valid    (b_valid),
        .i_fb_data              (b_fb_in),
        .i_db_data              (b_db_in),
        .o_buf_write_en         (b_en),
        .o_buf_write_addr       (b_waddr),
        .o_buf_write_sel        (b_sel),
        .o_fb_data              (b_fb),
        .o_db_data              (b_db)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready_a(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (a_ready) break;
            tick();
        end
        chk(tag, 32'(a_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;

        rst = 1'b1;
        a_clear = 0; a_done = 0; a_fs = 0; a_valid = 0;
        a_addr = '0; a_fb_in = '0; a_db_in = '0;
        b_clear = 0; b_done = 0; b_fs = 0; b_valid = 0;
        b_addr = '0; b_fb_in = '0; b_db_in = '0;
        tick();
        tick();
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_target", 32'(a_target), 32'd0);
        chk("rst_en", 32'(a_en), 32'd0);
        chk("rst_addr", 32'(a_waddr), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(a_ready), 32'd1);
        chk("idle_swapped", 32'(a_swapped), 32'd0);
        chk("idle_dropped", 32'(a_dropped), 32'd0);

        // Clear sweep over 8 pixels
        a_clear = 1; tick(); a_clear = 0;
        for (int i = 0; i < 8; i++) begin
            chk("clr_en", 32'(a_en), 32'd1);
            chk("clr_addr", 32'(a_waddr), 32'(i));
            chk("clr_fb", 32'(a_fb), 32'h0);
            chk("clr_db", 32'(a_db), 32'hfff);
            chk("clr_ready", 32'(a_ready), 32'd0);
            tick();
        end
        chk("clr_done_ready", 32'(a_ready), 32'd1);
        chk("clr_done_en", 32'(a_en), 32'd0);

        // Pass-through write in READY
        a_valid = 1; a_addr = 4'd5; a_fb_in = 4'd3; a_db_in = 12'h123;
        tick(); a_valid = 0;
        chk("wr_en", 32'(a_en), 32'd1);
        chk("wr_addr", 32'(a_waddr), 32'd5);
        chk("wr_sel", 32'(a_sel), 32'd0);
        chk("wr_fb", 32'(a_fb), 32'h3);
        chk("wr_db", 32'(a_db), 32'h123);
        tick();
        chk("wr_idle_en", 32'(a_en), 32'd0);
        chk("wr_dropped", 32'(a_dropped), 32'd0);

        // Write during clearing is dropped
        a_clear = 1; tick(); a_clear = 0;
        a_valid = 1; a_addr = 4'd2; a_fb_in = 4'd7; a_db_in = 12'h456;
        tick(); a_valid = 0;
        chk("drop_clr_addr", 32'(a_waddr), 32'd1);
        chk("drop_clr_fb", 32'(a_fb), 32'h0);
        chk("drop_clr_db", 32'(a_db), 32'hfff);
        chk("drop_flag", 32'(a_dropped), 32'd1);
        wait_ready_a("drop_clr_done");
        chk("drop_sticky", 32'(a_dropped), 32'd1);

        // Last in-range address accepted, flag stays sticky
        a_valid = 1; a_addr = 4'd7; a_fb_in = 4'hf; a_db_in = 12'habc;
        tick(); a_valid = 0;
        chk("edge_en", 32'(a_en), 32'd1);
        chk("edge_addr", 32'(a_waddr), 32'd7);
        chk("edge_fb", 32'(a_fb), 32'hf);
        chk("edge_db", 32'(a_db), 32'habc);
        chk("drop_sticky2", 32'(a_dropped), 32'd1);
        a_clear = 1; tick(); a_clear = 0;
        chk("drop_cleared", 32'(a_dropped), 32'd0);
        wait_ready_a("clr3_done");

        // Out-of-range address dropped
        a_valid = 1; a_addr = 4'd8; a_fb_in = 4'd5; a_db_in = 12'h555;
        tick(); a_valid = 0;
        chk("oob_en", 32'(a_en), 32'd0);
        chk("oob_dropped", 32'(a_dropped), 32'd1);

        // Frame start ignored in READY
        a_fs = 1; tick(); a_fs = 0;
        chk("fs_idle_swapped", 32'(a_swapped), 32'd0);
        chk("fs_idle_target", 32'(a_target), 32'd0);

        // Swap 0 -> 1
        a_done = 1; tick(); a_done = 0;
        a_valid = 1; a_addr = 4'd1; tick(); a_valid = 0;
        chk("wait_wr_en", 32'(a_en), 32'd0);
        for (int i = 0; i < 9; i++) begin
            chk("wait_swapped", 32'(a_swapped), 32'd0);
            tick();
        end
        a_fs = 1; tick(); a_fs = 0;
        chk("swap1_pulse", 32'(a_swapped), 32'd1);
        chk("swap1_target", 32'(a_target), 32'd1);
        chk("swap1_ready", 32'(a_ready), 32'd1);
        a_valid = 1; a_addr = 4'd3; a_fb_in = 4'd9; tick(); a_valid = 0;
        chk("swap1_pulse_end", 32'(a_swapped), 32'd0);
        chk("swap1_sel", 32'(a_sel), 32'd1);
        chk("swap1_wr_en", 32'(a_en), 32'd1);

        // Swap 1 -> 0
        a_done = 1; tick(); a_done = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("swap2_pre", 32'(a_target), 32'd1);
        a_fs = 1; tick(); a_fs = 0;
        chk("swap2_pulse", 32'(a_swapped), 32'd1);
        chk("swap2_target", 32'(a_target), 32'd0);
        tick();
        chk("swap2_pulse_end", 32'(a_swapped), 32'd0);

        // Clear wins over render_done
        a_clear = 1; a_done = 1; tick(); a_clear = 0; a_done = 0;
        chk("both_ready", 32'(a_ready), 32'd0);
        chk("both_en", 32'(a_en), 32'd1);
        chk("both_addr", 32'(a_waddr), 32'd0);
        wait_ready_a("both_clr_done");
        a_fs = 1; tick(); a_fs = 0;
        chk("both_noswap", 32'(a_swapped), 32'd0);
        chk("both_target", 32'(a_target), 32'd0);

        // render_done with coincident frame start: swap on the next one
        a_done = 1; a_fs = 1; tick(); a_done = 0; a_fs = 0;
        chk("same_noswap", 32'(a_swapped), 32'd0);
        chk("same_target", 32'(a_target), 32'd0);
        tick(); tick();
        a_fs = 1; tick(); a_fs = 0;
        chk("same_swap", 32'(a_swapped), 32'd1);
        chk("same_target2", 32'(a_target), 32'd1);

        // Asynchronous reset mid-sweep
        a_clear = 1; tick(); a_clear = 0;
        a_valid = 1; a_addr = 4'd4; tick(); a_valid = 0;
        tick();
        chk("pre_arst_dropped", 32'(a_dropped), 32'd1);
        chk("pre_arst_en", 32'(a_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(a_ready), 32'd1);
        chk("arst_en", 32'(a_en), 32'd0);
        chk("arst_target", 32'(a_target), 32'd0);
        chk("arst_addr", 32'(a_waddr), 32'd0);
        chk("arst_dropped", 32'(a_dropped), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(a_ready), 32'd1);
        chk("post_rst_en", 32'(a_en), 32'd0);
        a_clear = 1; tick(); a_clear = 0;
        chk("restart_addr0", 32'(a_waddr), 32'd0);
        chk("restart_en", 32'(a_en), 32'd1);
        tick();
        chk("restart_addr1", 32'(a_waddr), 32'd1);
        wait_ready_a("restart_done");

        // Default-size full sweep
        b_clear = 1; tick(); b_clear = 0;
        chk("b_first_addr", 32'(b_waddr), 32'd0);
        chk("b_first_db", 32'(b_db), 32'hfff);
        chk("b_first_fb", 32'(b_fb), 32'h0);
        chk("b_busy_ready", 32'(b_ready), 32'd0);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 80000; i++) begin
            if (b_ready) break;
            if (b_en) begin
                if (b_waddr != 17'(cnt)) bad++;
                cnt++;
            end
            tick();
        end
        chk("b_done_ready", 32'(b_ready), 32'd1);
        chk("b_writes", 32'(cnt), 32'd76800);
        chk("b_order", 32'(bad), 32'd0);
        b_valid = 1; b_addr = 17'd76799; b_fb_in = 4'd9; b_db_in = 12'h321;
        tick(); b_valid = 0;
        chk("b_edge_en", 32'(b_en), 32'd1);
        chk("b_edge_addr", 32'(b_waddr), 32'd76799);
        chk("b_edge_fb", 32'(b_fb), 32'h9);
        chk("b_edge_db", 32'(b_db), 32'h321);
        chk("b_edge_sel", 32'(b_sel), 32'd0);
        b_valid = 1; b_addr = 17'd76800; tick(); b_valid = 0;
        chk("b_oob_en", 32'(b_en), 32'd0);
        chk("b_oob_dropped", 32'(b_dropped), 32'd1);
        chk("b_swapped", 32'(b_swapped), 32'd0);
        chk("b_target", 32'(b_target), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
